// File: rtl/alu_arbiter_if.sv
// Bundle of requester, shared-ALU and response signals between two requesters and alu_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface alu_arbiter_if #(
  parameter int unsigned WIDTH = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_x;
  logic [WIDTH-1:0] req0_y;
  logic [5:0]       req0_op;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_x;
  logic [WIDTH-1:0] req1_y;
  logic [5:0]       req1_op;

  logic [WIDTH-1:0] alu_x;
  logic [WIDTH-1:0] alu_y;
  logic [5:0]       alu_op;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zr;
  logic             alu_ng;

  logic             resp0_valid;
  logic             resp0_ready;
  logic             resp1_valid;
  logic             resp1_ready;
  logic [WIDTH-1:0] resp_data;
  logic             resp_zr;
  logic             resp_ng;
  logic             resp_err;
  logic             busy;

  modport slave (
    input  req0_valid, req0_x, req0_y, req0_op,
    input  req1_valid, req1_x, req1_y, req1_op,
    input  alu_out, alu_zr, alu_ng,
    input  resp0_ready, resp1_ready,
    output req0_ready, req1_ready,
    output alu_x, alu_y, alu_op,
    output resp0_valid, resp1_valid, resp_data, resp_zr, resp_ng, resp_err,
    output busy
  );

  modport master (
    output req0_valid, req0_x, req0_y, req0_op,
    output req1_valid, req1_x, req1_y, req1_op,
    output alu_out, alu_zr, alu_ng,
    output resp0_ready, resp1_ready,
    input  req0_ready, req1_ready,
    input  alu_x, alu_y, alu_op,
    input  resp0_valid, resp1_valid, resp_data, resp_zr, resp_ng, resp_err,
    input  busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU: accept, execute one
// cycle, then hold the response until the granted requester takes it.
module alu_arbiter #(
  parameter int unsigned WIDTH = 16
) (
  input logic         clk,
  input logic         rst_n,
  alu_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             grant_q;
  logic             last_q;
  logic [WIDTH-1:0] x_q, y_q, data_q;
  logic [5:0]       op_q;
  logic             zr_q, ng_q, err_q;

  logic any_valid, pick, accept, done;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
      6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
      6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    // Under contention favour the requester that was not served last.
    pick      = (bus.req0_valid & bus.req1_valid) ? ~last_q : bus.req1_valid;
    // Gating by rst_n keeps a reset cycle from strobing a ready that is never honoured.
    accept    = rst_n & (state_q == IDLE) & any_valid;
    done      = (state_q == RESP) & (grant_q ? bus.resp1_ready : bus.resp0_ready);

    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      x_q     <= '0;
      y_q     <= '0;
      op_q    <= '0;
      data_q  <= '0;
      zr_q    <= 1'b0;
      ng_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        grant_q <= pick;
        x_q     <= pick ? bus.req1_x  : bus.req0_x;
        y_q     <= pick ? bus.req1_y  : bus.req0_y;
        op_q    <= pick ? bus.req1_op : bus.req0_op;
      end
      if (state_q == EXEC) begin
        if (op_legal(op_q)) begin
          data_q <= bus.alu_out;
          zr_q   <= bus.alu_zr;
          ng_q   <= bus.alu_ng;
          err_q  <= 1'b0;
        end else begin
          data_q <= '0;
          zr_q   <= 1'b0;
          ng_q   <= 1'b0;
          err_q  <= 1'b1;
        end
      end
      if (done) last_q <= grant_q;
    end
  end

  assign bus.req0_ready  = accept & ~pick;
  assign bus.req1_ready  = accept & pick;
  assign bus.alu_x       = x_q;
  assign bus.alu_y       = y_q;
  assign bus.alu_op      = op_q;
  assign bus.resp0_valid = (state_q == RESP) & ~grant_q;
  assign bus.resp1_valid = (state_q == RESP) & grant_q;
  assign bus.resp_data   = data_q;
  assign bus.resp_zr     = zr_q;
  assign bus.resp_ng     = ng_q;
  assign bus.resp_err    = err_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: bit-level ALU attached to the bus, directed scenarios, then random
// traffic checked against a transaction-level model using the op-code meaning table.
module tb_alu_arbiter;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(W)) bus ();

  alu_arbiter #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Environment ALU: zx,nx,zy,ny,f,no datapath.
  logic [W-1:0] ax, ay, ao;
  always_comb begin
    ax = bus.alu_op[5] ? '0 : bus.alu_x;
    if (bus.alu_op[4]) ax = ~ax;
    ay = bus.alu_op[3] ? '0 : bus.alu_y;
    if (bus.alu_op[2]) ay = ~ay;
    ao = bus.alu_op[1] ? ax + ay : ax & ay;
    if (bus.alu_op[0]) ao = ~ao;
    bus.alu_out = ao;
    bus.alu_zr  = (ao == '0);
    bus.alu_ng  = ao[W-1];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected result from the meaning of each op code.
  function automatic void ref_alu(input logic [5:0] op, input logic [W-1:0] x,
                                  input logic [W-1:0] y, output logic [W-1:0] d,
                                  output logic zr, output logic ng, output logic err);
    err = 1'b0;
    d   = '0;
    case (op)
      6'b101010: d = '0;
      6'b111111: d = W'(1);
      6'b111010: d = '1;
      6'b001100: d = x;
      6'b110000: d = y;
      6'b001101: d = ~x;
      6'b110001: d = ~y;
      6'b001111: d = -x;
      6'b110011: d = -y;
      6'b011111: d = x + W'(1);
      6'b110111: d = y + W'(1);
      6'b001110: d = x - W'(1);
      6'b110010: d = y - W'(1);
      6'b000010: d = x + y;
      6'b010011: d = x - y;
      6'b000111: d = y - x;
      6'b000000: d = x & y;
      6'b010101: d = x | y;
      default:   err = 1'b1;
    endcase
    zr = !err && (d == '0);
    ng = !err && d[W-1];
  endfunction

  logic [5:0] legal_ops [18] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000,
                                 6'b001101, 6'b110001, 6'b001111, 6'b110011, 6'b011111,
                                 6'b110111, 6'b001110, 6'b110010, 6'b000010, 6'b010011,
                                 6'b000111, 6'b000000, 6'b010101};

  // Transaction-level model: one outstanding job, its age in cycles, and who was served last.
  bit           m_pending = 1'b0;
  int           m_age = 0;
  bit           m_who = 1'b0;
  bit           m_last = 1'b1;
  logic [W-1:0] m_x = '0, m_y = '0, m_data = '0;
  logic [5:0]   m_op = '0;
  logic         m_zr = 1'b0, m_ng = 1'b0, m_err = 1'b0;

  task automatic model_check();
    logic [1:0] e_rdy, e_rv;
    logic g, acc;
    e_rdy = '0; e_rv = '0; g = 1'b0; acc = 1'b0;
    if (!m_pending) begin
      if (rst_n && (bus.req0_valid || bus.req1_valid)) begin
        acc = 1'b1;
        g = (bus.req0_valid && bus.req1_valid) ? ~m_last : bus.req1_valid;
        e_rdy[g] = 1'b1;
      end
    end else if (m_age >= 2) begin
      e_rv[m_who] = 1'b1;
    end
    check("req0_ready", 32'(bus.req0_ready), 32'(e_rdy[0]));
    check("req1_ready", 32'(bus.req1_ready), 32'(e_rdy[1]));
    check("resp0_valid", 32'(bus.resp0_valid), 32'(e_rv[0]));
    check("resp1_valid", 32'(bus.resp1_valid), 32'(e_rv[1]));
    check("busy", 32'(bus.busy), 32'(m_pending));
    check("alu_x", 32'(bus.alu_x), 32'(m_x));
    check("alu_y", 32'(bus.alu_y), 32'(m_y));
    check("alu_op", 32'(bus.alu_op), 32'(m_op));
    if (e_rv != 2'b00) begin
      check("resp_data", 32'(bus.resp_data), 32'(m_data));
      check("resp_zr", 32'(bus.resp_zr), 32'(m_zr));
      check("resp_ng", 32'(bus.resp_ng), 32'(m_ng));
      check("resp_err", 32'(bus.resp_err), 32'(m_err));
    end
    if (!rst_n) begin
      m_pending = 1'b0; m_last = 1'b1; m_x = '0; m_y = '0; m_op = '0;
    end else if (acc) begin
      m_pending = 1'b1; m_age = 1; m_who = g;
      m_x  = g ? bus.req1_x  : bus.req0_x;
      m_y  = g ? bus.req1_y  : bus.req0_y;
      m_op = g ? bus.req1_op : bus.req0_op;
      ref_alu(m_op, m_x, m_y, m_data, m_zr, m_ng, m_err);
    end else if (m_pending) begin
      if (m_age >= 2 && (m_who ? bus.resp1_ready : bus.resp0_ready)) begin
        m_pending = 1'b0; m_last = m_who;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic drive(input logic rst, input logic v0, input logic v1,
                       input logic [W-1:0] x0, input logic [W-1:0] y0, input logic [5:0] op0,
                       input logic [W-1:0] x1, input logic [W-1:0] y1, input logic [5:0] op1,
                       input logic r0, input logic r1);
    rst_n = rst;
    bus.req0_valid = v0; bus.req0_x = x0; bus.req0_y = y0; bus.req0_op = op0;
    bus.req1_valid = v1; bus.req1_x = x1; bus.req1_y = y1; bus.req1_op = op1;
    bus.resp0_ready = r0; bus.resp1_ready = r1;
  endtask

  task automatic drive_idle();
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0, 1'b1, 1'b1);
  endtask

  task automatic fin();
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    @(negedge clk);
    fin();
  endtask

  // Accept a single request and run through EXEC; returns at the start of the RESP cycle.
  task automatic issue(input logic who, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [5:0] op);
    if (who) drive(1'b1, 1'b0, 1'b1, '0, '0, '0, x, y, op, 1'b1, 1'b1);
    else     drive(1'b1, 1'b1, 1'b0, x, y, op, '0, '0, '0, 1'b1, 1'b1);
    @(negedge clk);
    check("accept_ready", 32'(who ? bus.req1_ready : bus.req0_ready), 32'd1);
    fin();
    drive_idle();
    cyc();
    drive_idle();
  endtask

  int grants[$];

  initial begin
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    drive_idle();
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_resp0_valid", 32'(bus.resp0_valid), 32'd0);
    check("rst_resp1_valid", 32'(bus.resp1_valid), 32'd0);
    check("rst_alu_x", 32'(bus.alu_x), 32'd0);
    check("rst_alu_op", 32'(bus.alu_op), 32'd0);
    check("rst_resp_data", 32'(bus.resp_data), 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    fin();

    // Single request: 5 + 3.
    issue(1'b0, 16'd5, 16'd3, 6'b000010);
    @(negedge clk);
    check("single_valid", 32'(bus.resp0_valid), 32'd1);
    check("single_data", 32'(bus.resp_data), 32'd8);
    check("single_flags", 32'({bus.resp_zr, bus.resp_ng, bus.resp_err}), 32'd0);
    fin();

    // Contention right after reset.
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0, 1'b1, 1'b1);
    cyc();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b1, 1'b1, 16'd10, 16'd1, 6'b000010, 16'd20, 16'd2, 6'b000010, 1'b1, 1'b1);
      @(negedge clk);
      if (bus.req0_ready) grants.push_back(0);
      if (bus.req1_ready) grants.push_back(1);
      fin();
    end
    check("grant_count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < grants.size()) check("grant_order", 32'(grants[i]), 32'(i % 2));
    end
    drive_idle();
    repeat (3) cyc();

    // Negative and zero results.
    issue(1'b1, 16'd3, 16'd5, 6'b010011);
    @(negedge clk);
    check("neg_data", 32'(bus.resp_data), 32'h0000_FFFE);
    check("neg_ng", 32'(bus.resp_ng), 32'd1);
    fin();
    issue(1'b1, 16'd3, 16'd5, 6'b101010);
    @(negedge clk);
    check("zero_data", 32'(bus.resp_data), 32'd0);
    check("zero_zr", 32'(bus.resp_zr), 32'd1);
    fin();

    // Illegal op code.
    issue(1'b0, 16'd7, 16'd7, 6'b100000);
    @(negedge clk);
    check("illegal_valid", 32'(bus.resp0_valid), 32'd1);
    check("illegal_err", 32'(bus.resp_err), 32'd1);
    check("illegal_payload", 32'({bus.resp_data, bus.resp_zr, bus.resp_ng}), 32'd0);
    fin();

    // Backpressure on requester 0 while requester 1 waits.
    issue(1'b0, 16'd7, 16'd9, 6'b000010);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 1'b1, '0, '0, '0, 16'd1, 16'd1, 6'b000010, 1'b0, 1'b1);
      @(negedge clk);
      check("bp_valid", 32'(bus.resp0_valid), 32'd1);
      check("bp_data", 32'(bus.resp_data), 32'd16);
      check("bp_busy", 32'(bus.busy), 32'd1);
      check("bp_req1_ready", 32'(bus.req1_ready), 32'd0);
      fin();
    end
    drive(1'b1, 1'b0, 1'b1, '0, '0, '0, 16'd1, 16'd1, 6'b000010, 1'b1, 1'b1);
    cyc();
    @(negedge clk);
    check("bp_release_idle", 32'(bus.busy), 32'd0);
    check("bp_release_grant1", 32'(bus.req1_ready), 32'd1);
    fin();
    drive_idle();
    repeat (3) cyc();

    // Reset while a response is pending.
    issue(1'b0, 16'd1, 16'd2, 6'b000010);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 1'b1, 1'b1, 16'd4, 16'd4, 6'b000010, 16'd6, 16'd6, 6'b000010, 1'b1, 1'b1);
    @(negedge clk);
    check("mrst_busy", 32'(bus.busy), 32'd0);
    check("mrst_resp_valid", 32'({bus.resp0_valid, bus.resp1_valid}), 32'd0);
    check("mrst_alu_x", 32'(bus.alu_x), 32'd0);
    check("mrst_resp_data", 32'(bus.resp_data), 32'd0);
    check("mrst_grant0", 32'({bus.req1_ready, bus.req0_ready}), 32'd1);
    fin();
    drive_idle();
    repeat (3) cyc();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] op0, op1;
      op0 = ($urandom_range(0, 3) != 0) ? legal_ops[$urandom_range(0, 17)] : 6'($urandom);
      op1 = ($urandom_range(0, 3) != 0) ? legal_ops[$urandom_range(0, 17)] : 6'($urandom);
      drive(logic'($urandom_range(0, 199) != 0),
            logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
            W'($urandom), W'($urandom), op0, W'($urandom), W'($urandom), op1,
            logic'($urandom_range(0, 9) < 7), logic'($urandom_range(0, 9) < 7));
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
